// File: rtl/radar_sweep_sequencer.sv
// Radar scan sequencer: steps the servo through N_STEPS positions in a ping-pong sweep,
// triggers one telemeter measurement per settled position and writes {timeout,dist} per angle.
module radar_sweep_sequencer #(
  parameter int N_STEPS       = 32,
  parameter int STEP_W        = 8,
  parameter int SETTLE_CYCLES = 5_000_000,
  parameter int MEAS_TIMEOUT  = 3_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [STEP_W-1:0] angle_o,
  output logic              meas_start,
  input  logic              meas_done,
  input  logic [9:0]        dist_i,
  output logic              wr_en,
  output logic [STEP_W-1:0] wr_addr,
  output logic [10:0]       wr_data,
  output logic              sweep_done,
  output logic              sweep_dir,
  output logic              busy
);

  // One counter serves both the settle delay and the measurement timeout.
  localparam int CNT_MAX = (SETTLE_CYCLES > MEAS_TIMEOUT) ? SETTLE_CYCLES : MEAS_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  WAIT_LAST   = CNT_W'(MEAS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [STEP_W-1:0] IDX_LAST    = STEP_W'(N_STEPS - 1);
  localparam logic [STEP_W-1:0] IDX_ONE     = STEP_W'(1);

  typedef enum logic [2:0] {IDLE, SETTLE, TRIG, WAIT, STORE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STEP_W-1:0] idx_q, idx_d;
  logic              dir_q, dir_d;
  logic [STEP_W-1:0] wr_addr_q, wr_addr_d;
  logic [10:0]       wr_data_q, wr_data_d;
  logic              sweep_done_q, sweep_done_d;
  logic              meas_start_q, meas_start_d;
  logic              wr_en_q, wr_en_d;
  logic              busy_q, busy_d;
  logic              at_end;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    dir_d        = dir_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    sweep_done_d = 1'b0;
    at_end       = dir_q ? (idx_q == '0) : (idx_q == IDX_LAST);

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = TRIG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      TRIG: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        // A done arriving on the timeout cycle still delivers the real distance.
        if (meas_done || cnt_q == WAIT_LAST) begin
          state_d      = STORE;
          wr_addr_d    = idx_q;
          wr_data_d    = meas_done ? {1'b0, dist_i} : 11'h7FF;
          sweep_done_d = at_end;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STORE: begin
        state_d = enable ? SETTLE : IDLE;
        cnt_d   = '0;
        if (at_end) begin
          dir_d = ~dir_q;
          if (N_STEPS > 1) idx_d = dir_q ? idx_q + IDX_ONE : idx_q - IDX_ONE;
        end else begin
          idx_d = dir_q ? idx_q - IDX_ONE : idx_q + IDX_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Strobes are registered from the next state so they line up with that state.
    meas_start_d = (state_d == TRIG);
    wr_en_d      = (state_d == STORE);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      dir_q        <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      sweep_done_q <= 1'b0;
      meas_start_q <= 1'b0;
      wr_en_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      dir_q        <= dir_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      sweep_done_q <= sweep_done_d;
      meas_start_q <= meas_start_d;
      wr_en_q      <= wr_en_d;
      busy_q       <= busy_d;
    end
  end

  assign angle_o    = idx_q;
  assign sweep_dir  = dir_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign sweep_done = sweep_done_q;
  assign meas_start = meas_start_q;
  assign wr_en      = wr_en_q;
  assign busy       = busy_q;

endmodule
